// File: rtl/alu_core_if.sv
// Control/data bus for alu_core: operands, mode/opcode selects, irq clear, and
// the registered result and interrupt.
interface alu_core_if #(
  parameter int DATA_W = 8
);
  logic              alu_enable;
  logic              alu_enable_a;
  logic              alu_enable_b;
  logic              alu_irq_clr;
  logic [1:0]        alu_op_a;
  logic [1:0]        alu_op_b;
  logic [DATA_W-1:0] alu_in_a;
  logic [DATA_W-1:0] alu_in_b;
  logic              alu_irq;
  logic [DATA_W-1:0] alu_out;

  modport master (
    output alu_enable, alu_enable_a, alu_enable_b, alu_irq_clr,
    output alu_op_a, alu_op_b, alu_in_a, alu_in_b,
    input  alu_irq, alu_out
  );

  modport slave (
    input  alu_enable, alu_enable_a, alu_enable_b, alu_irq_clr,
    input  alu_op_a, alu_op_b, alu_in_a, alu_in_b,
    output alu_irq, alu_out
  );
endinterface

// File: rtl/alu_core.sv
// Registered two-mode 8-bit logic ALU with a sticky trigger interrupt.
// Define ALU_ILLEGAL_IRQ_EN to also raise the irq when both modes are selected.
module alu_core #(
  parameter int DATA_W = 8
) (
  input logic       alu_clk,
  input logic       rst_n,    // active-high synchronous reset despite the name
  alu_core_if.slave bus
);

  logic [DATA_W-1:0] r_out;
  logic              r_irq;
  logic [DATA_W-1:0] w_result;
  logic              w_trigger;
  logic              w_valid;
  logic              w_irq_set;

  assign w_valid = bus.alu_enable & (bus.alu_enable_a ^ bus.alu_enable_b);

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch is inferred.
    w_result  = '0;
    w_trigger = 1'b0;
    if (bus.alu_enable_a) begin
      case (bus.alu_op_a)
        2'b00: begin
          w_result  = bus.alu_in_a & bus.alu_in_b;
          w_trigger = (w_result == DATA_W'(8'hFF));
        end
        2'b01: begin
          w_result  = ~(bus.alu_in_a & bus.alu_in_b);
          w_trigger = (w_result == DATA_W'(8'h00));
        end
        2'b10: begin
          w_result  = bus.alu_in_a | bus.alu_in_b;
          w_trigger = (w_result == DATA_W'(8'hF8));
        end
        default: begin
          w_result  = bus.alu_in_a ^ bus.alu_in_b;
          w_trigger = (w_result == DATA_W'(8'h83));
        end
      endcase
    end else begin
      case (bus.alu_op_b)
        2'b00: begin
          w_result  = ~(bus.alu_in_a ^ bus.alu_in_b);
          w_trigger = (w_result == DATA_W'(8'hF1));
        end
        2'b01: begin
          w_result  = bus.alu_in_a & bus.alu_in_b;
          w_trigger = (w_result == DATA_W'(8'hF4));
        end
        2'b10: begin
          w_result  = ~(bus.alu_in_a | bus.alu_in_b);
          w_trigger = (w_result == DATA_W'(8'hF5));
        end
        default: begin
          w_result  = bus.alu_in_a | bus.alu_in_b;
          w_trigger = (w_result == DATA_W'(8'hFF));
        end
      endcase
    end
  end

`ifdef ALU_ILLEGAL_IRQ_EN
  logic w_illegal;
  assign w_illegal = bus.alu_enable & bus.alu_enable_a & bus.alu_enable_b;
  assign w_irq_set = (w_valid & w_trigger) | w_illegal;
`else
  assign w_irq_set = w_valid & w_trigger;
`endif

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge alu_clk) begin
    if (rst_n) begin
      r_out <= '0;
      r_irq <= 1'b0;
    end else begin
      if (w_valid)
        r_out <= w_result;
      // Set has priority over a simultaneous clear.
      if (w_irq_set)
        r_irq <= 1'b1;
      else if (bus.alu_irq_clr)
        r_irq <= 1'b0;
    end
  end

  assign bus.alu_out = r_out;
  assign bus.alu_irq = r_irq;

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed test-plan steps, then randomized
// cycles compared against a table-driven reference model.
module tb_alu_core;

  localparam int DATA_W = 8;

  logic alu_clk = 1'b0;
  logic rst_n   = 1'b1;

  alu_core_if #(.DATA_W(DATA_W)) bus ();

  alu_core #(.DATA_W(DATA_W)) dut (
    .alu_clk (alu_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 alu_clk = ~alu_clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_out = 8'h00;
  logic       exp_irq = 1'b0;

  localparam logic [7:0] TRIG_A [4] = '{8'hFF, 8'h00, 8'hF8, 8'h83};
  localparam logic [7:0] TRIG_B [4] = '{8'hF1, 8'hF4, 8'hF5, 8'hFF};

  function automatic logic [7:0] ref_result(bit mode_b, logic [1:0] op,
                                            logic [7:0] a, logic [7:0] b);
    if (!mode_b) begin
      case (op)
        2'd0:    return a & b;
        2'd1:    return ~(a & b);
        2'd2:    return a | b;
        default: return a ^ b;
      endcase
    end else begin
      case (op)
        2'd0:    return ~(a ^ b);
        2'd1:    return a & b;
        2'd2:    return ~(a | b);
        default: return a | b;
      endcase
    end
  endfunction

  task automatic check(string tag, logic [7:0] observed, logic [7:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One clock: drive on the falling edge, advance the model at the rising
  // edge, compare both outputs just after it.
  task automatic step(string tag, bit rst, bit en, bit ea, bit eb, bit clr,
                      logic [1:0] opa, logic [1:0] opb,
                      logic [7:0] a, logic [7:0] b);
    bit         mode_b;
    bit         set;
    logic [1:0] op;
    logic [7:0] r;
    @(negedge alu_clk);
    rst_n            = rst;
    bus.alu_enable   = en;
    bus.alu_enable_a = ea;
    bus.alu_enable_b = eb;
    bus.alu_irq_clr  = clr;
    bus.alu_op_a     = opa;
    bus.alu_op_b     = opb;
    bus.alu_in_a     = a;
    bus.alu_in_b     = b;
    @(posedge alu_clk);
    if (rst) begin
      exp_out = 8'h00;
      exp_irq = 1'b0;
    end else begin
      set = 1'b0;
      if (en && (ea != eb)) begin
        mode_b  = eb;
        op      = mode_b ? opb : opa;
        r       = ref_result(mode_b, op, a, b);
        exp_out = r;
        set     = (r == (mode_b ? TRIG_B[op] : TRIG_A[op]));
      end
`ifdef ALU_ILLEGAL_IRQ_EN
      if (en && ea && eb) set = 1'b1;
`endif
      if (set)      exp_irq = 1'b1;
      else if (clr) exp_irq = 1'b0;
    end
    #1;
    check({tag, "_out"}, bus.alu_out, exp_out);
    check({tag, "_irq"}, {7'd0, bus.alu_irq}, {7'd0, exp_irq});
  endtask

  logic [1:0] ops [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
  logic [7:0] sweep_a [4] = '{8'h30, 8'hCF, 8'hFC, 8'hCC};
  logic [7:0] sweep_b [4] = '{8'h33, 8'h30, 8'h03, 8'hFC};

  initial begin
    bus.alu_enable   = 1'b0;
    bus.alu_enable_a = 1'b0;
    bus.alu_enable_b = 1'b0;
    bus.alu_irq_clr  = 1'b0;
    bus.alu_op_a     = 2'd0;
    bus.alu_op_b     = 2'd0;
    bus.alu_in_a     = 8'h00;
    bus.alu_in_b     = 8'h00;

    // Reset held for two cycles while other inputs are random.
    for (int i = 0; i < 2; i++)
      step("reset", 1'b1, 1'b1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           1'b0, 2'($urandom), 2'($urandom), 8'($urandom), 8'($urandom));
    check("reset_out_zero", bus.alu_out, 8'h00);
    step("post_reset_idle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 8'hFF, 8'hFF);
    check("post_reset_hold", bus.alu_out, 8'h00);

    for (int i = 0; i < 4; i++) begin
      step("modeA_sweep", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ops[i], 2'($urandom), 8'hF0, 8'h3C);
      check("modeA_const", bus.alu_out, sweep_a[i]);
    end
    for (int i = 0; i < 4; i++) begin
      step("modeB_sweep", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'($urandom), ops[i], 8'hF0, 8'h3C);
      check("modeB_const", bus.alu_out, sweep_b[i]);
    end

    step("irqA_set", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 8'hFF, 8'hFF);
    check("irqA_set_const", {7'd0, bus.alu_irq}, 8'h01);
    step("irqA_sticky", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 2'd0, 8'h01, 8'h02);
    check("irqA_sticky_out", bus.alu_out, 8'h03);
    step("irqA_clr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 8'h00, 8'h00);
    check("irqA_clr_const", {7'd0, bus.alu_irq}, 8'h00);
    step("irqA_setwins", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 8'hFF, 8'hFF);
    check("irqA_setwins_const", {7'd0, bus.alu_irq}, 8'h01);
    step("irq_clr2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 8'h00, 8'h00);

    step("irqB_noirq", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd3, 8'hF1, 8'hF1);
    check("irqB_noirq_out", bus.alu_out, 8'hF1);
    step("irqB_nor", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd2, 8'h0A, 8'h00);
    check("irqB_nor_out", bus.alu_out, 8'hF5);
    check("irqB_nor_irq", {7'd0, bus.alu_irq}, 8'h01);
    step("irq_clr3", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 8'h00, 8'h00);

    step("hold_load", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 8'hF0, 8'h3C);
    step("hold_disabled", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd1, 8'hAA, 8'h55);
    check("hold_disabled_const", bus.alu_out, 8'h30);
    step("hold_none", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 8'hAA, 8'h55);
    step("hold_illegal", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 8'hFF, 8'hFF);
    check("hold_illegal_const", bus.alu_out, 8'h30);
`ifdef ALU_ILLEGAL_IRQ_EN
    check("illegal_irq_const", {7'd0, bus.alu_irq}, 8'h01);
`else
    check("illegal_irq_const", {7'd0, bus.alu_irq}, 8'h00);
`endif

    step("midop_reset", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 8'hFF, 8'hFF);
    check("midop_reset_const", bus.alu_out, 8'h00);

    // Random cycles; equal operands now and then make trigger values likelier.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : 8'($urandom);
      step("rand", $urandom_range(0, 31) == 0, $urandom_range(0, 7) != 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom_range(0, 5) == 0, 2'($urandom), 2'($urandom), a, b);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
- Registered 8-bit logic ALU with two operation modes, A and B, each selecting one of four bitwise operations.
- Raises a sticky interrupt when the result hits a mode/op-specific trigger value; software clears it with alu_irq_clr.
- Single clock domain peripheral datapath block, driven directly by a control interface.

Parameters:
- DATA_W, 8, operand/result width; trigger constants below are defined for 8 bits.

Ports:
- alu_clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-high (asserted = 1). The name is kept for interface compatibility.
- alu_enable  in  1  global enable; 0 = no operation.
- alu_enable_a  in  1  select mode A.
- alu_enable_b  in  1  select mode B.
- alu_irq_clr  in  1  clears alu_irq.
- alu_op_a  in  2  mode A opcode.
- alu_op_b  in  2  mode B opcode.
- alu_in_a  in  DATA_W  operand A.
- alu_in_b  in  DATA_W  operand B.
- alu_irq  out  1  sticky interrupt, registered.
- alu_out  out  DATA_W  result, registered.

Behaviour:
- Reset (rst_n=1 at edge): alu_out=0x00, alu_irq=0. Reset has priority over all other inputs and takes effect mid-operation on the next edge.
- Valid cycle: alu_enable=1 and exactly one of alu_enable_a / alu_enable_b is 1. alu_out is updated at that edge, so latency = 1 clock from inputs to alu_out.
- Mode A opcodes:
  - 00: a AND b.
  - 01: NOT(a AND b).
  - 10: a OR b.
  - 11: a XOR b.
- Mode B opcodes:
  - 00: NOT(a XOR b).
  - 01: a AND b.
  - 10: NOT(a OR b).
  - 11: a OR b.
- The opcode of the non-selected mode is ignored.
- Invalid cycle: alu_enable=0, both mode enables 0, or both mode enables 1. alu_out holds its value and no irq is evaluated.
- IRQ triggers: evaluated on the newly computed result of a valid cycle. alu_irq is set at the same edge that loads alu_out.
  - Mode A: AND = 0xFF, NAND = 0x00, OR = 0xF8, XOR = 0x83.
  - Mode B: XNOR = 0xF1, AND = 0xF4, NOR = 0xF5, OR = 0xFF.
- alu_irq is sticky: it stays 1 until alu_irq_clr=1 at an edge, then goes to 0 on that edge.
- Simultaneous set and clear in the same cycle: set wins, so alu_irq remains 1.
- alu_irq_clr has no effect on alu_out.
- No combinational path from any input to any output.

Optional Feature:
- Macro: ALU_ILLEGAL_IRQ_EN.
- Defined: a cycle with alu_enable=1 and both alu_enable_a and alu_enable_b =1 sets alu_irq (sticky, same clear rules); alu_out still holds.
- Undefined: that cycle is silently ignored and alu_irq is unaffected.

Test Plan:
- Reset: assert rst_n=1 for 2 cycles with random inputs -> alu_out=0x00, alu_irq=0; deassert -> outputs stay 0 until a valid cycle.
- Mode A sweep: a=0xF0, b=0x3C, ops 00..11 -> alu_out = 0x30, 0xCF, 0xFC, 0xCC one cycle after each op; alu_irq=0.
- Mode B sweep: a=0xF0, b=0x3C, ops 00..11 -> alu_out = 0x33, 0x30, 0x03, 0xFC; alu_irq=0.
- IRQ set/clear (mode A):
  - a=0xFF, b=0xFF, op 00 -> alu_out=0xFF and alu_irq=1 next cycle.
  - Next cycle a=0x01, b=0x02, op 10 -> alu_out=0x03, irq stays 1.
  - Pulse alu_irq_clr -> alu_irq=0.
  - Repeat the trigger with clr held high -> irq=1 (set wins).
- IRQ (mode B): a=0xF1, b=0xF1, op 11 -> alu_out=0xF1, no irq. Then a=0x0A, b=0x00, op 10 -> alu_out=0xF5, alu_irq=1.
- Hold/illegal: after alu_out=0x30, drive alu_enable=0, then both mode enables=1 -> alu_out stays 0x30 throughout.
  - alu_irq stays 0 without ALU_ILLEGAL_IRQ_EN.
  - alu_irq becomes 1 with ALU_ILLEGAL_IRQ_EN.
